// File: rtl/twiddle_addr_gen_stage_8_if.sv
// Bus bundle for the stage-8 twiddle address generator: input stream, angle ROM port, output stream.
// The block sits on the slave modport; the surrounding pipeline drives the master side.
`timescale 1ns/1ps
interface twiddle_addr_gen_stage_8_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  logic              i_valid;
  logic              o_ready;
  logic              i_sof;
  logic [DATA_W-1:0] i_re;
  logic [DATA_W-1:0] i_im;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [31:0]       i_rom_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_re;
  logic [DATA_W-1:0] o_im;
  logic [31:0]       o_angle;
  logic              o_sof;
  logic              o_eof;
  logic              o_frame_err;

  modport master (
    output i_valid, i_sof, i_re, i_im, i_rom_data, i_ready,
    input  o_ready, o_rom_addr, o_valid, o_re, o_im, o_angle, o_sof, o_eof, o_frame_err
  );

  modport slave (
    input  i_valid, i_sof, i_re, i_im, i_rom_data, i_ready,
    output o_ready, o_rom_addr, o_valid, o_re, o_im, o_angle, o_sof, o_eof, o_frame_err
  );
endinterface

// File: rtl/twiddle_addr_gen_stage_8.sv
// Stage-8 twiddle front-end: tracks in-frame sample index, addresses the angle ROM and delays
// each sample by one cycle so it leaves together with its registered ROM angle.
`timescale 1ns/1ps
module twiddle_addr_gen_stage_8 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2N  = 8,
  parameter int unsigned ADDR_W = LOG2N - 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  twiddle_addr_gen_stage_8_if.slave bus
);

  logic              ready;
  logic              fire_in;
  logic [LOG2N-1:0]  idx;
  logic [ADDR_W-1:0] idx_addr;

  logic [LOG2N-1:0]  cnt_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic              valid_q;
  logic              sof_q;
  logic              eof_q;
  logic              frame_err_q;
  logic [DATA_W-1:0] re_q;
  logic [DATA_W-1:0] im_q;

  // Single register stage: a new sample may enter whenever the held one leaves this cycle.
  assign ready   = !valid_q || bus.i_ready;
  assign fire_in = bus.i_valid && ready;

  // Sum-branch half of the frame rotates by zero; the other half indexes the ROM directly.
  always_comb begin
    idx      = bus.i_sof ? '0 : cnt_q;
    idx_addr = idx[LOG2N-1] ? idx[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      hold_addr_q <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_err_q <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
    end else begin
      frame_err_q <= fire_in && bus.i_sof && (cnt_q != '0);
      if (fire_in) begin
        cnt_q       <= idx + LOG2N'(1);
        hold_addr_q <= idx_addr;
        valid_q     <= 1'b1;
        sof_q       <= (idx == '0);
        eof_q       <= &idx;
        re_q        <= bus.i_re;
        im_q        <= bus.i_im;
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // While stalled the ROM keeps re-reading the held sample's entry so its angle stays put.
  assign bus.o_rom_addr  = fire_in ? idx_addr : hold_addr_q;
  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_re        = re_q;
  assign bus.o_im        = im_q;
  assign bus.o_angle     = bus.i_rom_data;
  assign bus.o_sof       = sof_q;
  assign bus.o_eof       = eof_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_twiddle_addr_gen_stage_8.sv
// Self-checking bench for twiddle_addr_gen_stage_8: random handshake traffic against a
// frame-position reference model and an angle ROM computed from -2*pi*k/256 in Q16.16.
`timescale 1ns/1ps
module tb_twiddle_addr_gen_stage_8;
  localparam int  DATA_W = 32;
  localparam int  LOG2N  = 8;
  localparam int  ADDR_W = 7;
  localparam int  N      = 256;
  localparam real PI     = 3.14159265358979323846;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [31:0] angle;
    logic        sof;
    logic        eof;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_addr_gen_stage_8_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  twiddle_addr_gen_stage_8 #(.DATA_W(DATA_W), .LOG2N(LOG2N), .ADDR_W(ADDR_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Rotation angle for in-frame index idx, rounded to nearest Q16.16.
  function automatic logic [31:0] ref_angle(input int idx);
    real a;
    if (idx < N / 2) return 32'h0;
    a = 2.0 * PI * real'(idx - N / 2) / real'(N) * 65536.0;
    return 32'(-$rtoi(a + 0.5));
  endfunction

  // Registered-read angle ROM.
  always @(posedge clk) bus.i_rom_data <= ref_angle(int'(bus.o_rom_addr) + N / 2);

  out_t exp_q[$];
  out_t obs_q[$];
  int   mpos, exp_err, obs_err;
  int   n_checks = 0;
  int   n_pass = 0;

  logic              s_valid, s_ready;
  logic [31:0]       s_re, s_angle;
  logic [ADDR_W-1:0] s_addr;

  task automatic model_accept(input logic sof, input logic [31:0] re, input logic [31:0] im);
    int idx;
    idx = sof ? 0 : mpos;
    if (sof && mpos != 0) exp_err++;
    mpos = (idx + 1) % N;
    exp_q.push_back(out_t'({re, im, ref_angle(idx), 1'(idx == 0), 1'(idx == N - 1)}));
  endtask

  // One clock: drive at posedge+1, sample at negedge, count frame-error pulses after posedge.
  task automatic step(input logic v, input logic sof, input logic [31:0] re, input logic [31:0] im,
                      input logic rdy, output logic acc);
    bus.i_valid = v;
    bus.i_sof   = v ? sof : 1'($urandom());
    bus.i_re    = v ? re : $urandom();
    bus.i_im    = v ? im : $urandom();
    bus.i_ready = rdy;
    @(negedge clk);
    s_valid = bus.o_valid;
    s_ready = bus.o_ready;
    s_re    = bus.o_re;
    s_angle = bus.o_angle;
    s_addr  = bus.o_rom_addr;
    acc     = v && bus.o_ready;
    if (bus.o_valid && rdy)
      obs_q.push_back(out_t'({bus.o_re, bus.o_im, bus.o_angle, bus.o_sof, bus.o_eof}));
    if (acc) model_accept(sof, re, im);
    @(posedge clk);
    #1;
    if (bus.o_frame_err) obs_err++;
  endtask

  task automatic send(input logic sof, input logic [31:0] re, input int idle_pct,
                      input int ready_pct);
    logic        acc;
    logic [31:0] im;
    int          tries;
    im = $urandom();
    if ($urandom_range(0, 99) < idle_pct)
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'($urandom_range(0, 99) < ready_pct), acc);
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(1'b1, sof, re, im, 1'($urandom_range(0, 99) < ready_pct), acc);
      tries++;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", re, tries);
    end
  endtask

  task automatic drain(input int n);
    logic acc;
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;
    bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mpos = 0; exp_err = 0; obs_err = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.o_valid); else n_pass++;
    n_checks++; if (bus.o_re !== '0) $display("FAIL rst_re: got %h expected 0", bus.o_re); else n_pass++;
    n_checks++; if (bus.o_im !== '0) $display("FAIL rst_im: got %h expected 0", bus.o_im); else n_pass++;
    n_checks++; if (bus.o_sof !== 1'b0) $display("FAIL rst_sof: got %b expected 0", bus.o_sof); else n_pass++;
    n_checks++; if (bus.o_eof !== 1'b0) $display("FAIL rst_eof: got %b expected 0", bus.o_eof); else n_pass++;
    n_checks++; if (bus.o_frame_err !== 1'b0) $display("FAIL rst_ferr: got %b expected 0", bus.o_frame_err); else n_pass++;
    n_checks++; if (bus.o_rom_addr !== '0) $display("FAIL rst_addr: got %0d expected 0", bus.o_rom_addr); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bus.o_ready); else n_pass++;
  endtask

  task automatic test_frame();
    do_reset();
    for (int i = 0; i < N; i++) send(1'(i == 0), 32'(i), 0, 100);
    n_checks++;
    if (obs_q.size() !== N - 1) $display("FAIL frame_latency: got %0d outputs expected %0d", obs_q.size(), N - 1); else n_pass++;
    drain(2);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL frame_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL frame_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_q.size() >= N) begin
      n_checks++; if (obs_q[130].angle !== 32'hfffff36f) $display("FAIL angle_130: got %h expected fffff36f", obs_q[130].angle); else n_pass++;
      n_checks++; if (obs_q[192].angle !== 32'hfffe6de0) $display("FAIL angle_192: got %h expected fffe6de0", obs_q[192].angle); else n_pass++;
      n_checks++; if (obs_q[160].angle !== 32'hffff36f0) $display("FAIL angle_160: got %h expected ffff36f0", obs_q[160].angle); else n_pass++;
      n_checks++; if (obs_q[127].angle !== 32'h0) $display("FAIL angle_127: got %h expected 0", obs_q[127].angle); else n_pass++;
      n_checks++; if (obs_q[0].sof !== 1'b1) $display("FAIL sof_0: got %b expected 1", obs_q[0].sof); else n_pass++;
      n_checks++; if (obs_q[255].eof !== 1'b1) $display("FAIL eof_255: got %b expected 1", obs_q[255].eof); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic        acc;
    logic [31:0] im;
    do_reset();
    for (int i = 0; i <= 200; i++) send(1'(i == 0), 32'(i), 0, 100);
    im = $urandom();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 32'd201, im, 1'b0, acc);
      n_checks++; if (s_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", c, s_valid); else n_pass++;
      n_checks++; if (s_re !== 32'd200) $display("FAIL stall_re[%0d]: got %0d expected 200", c, s_re); else n_pass++;
      n_checks++; if (s_addr !== 7'd72) $display("FAIL stall_addr[%0d]: got %0d expected 72", c, s_addr); else n_pass++;
      n_checks++; if (s_angle !== 32'hfffe3b9c) $display("FAIL stall_angle[%0d]: got %h expected fffe3b9c", c, s_angle); else n_pass++;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b expected 0", c, s_ready); else n_pass++;
    end
    for (int i = 201; i < N; i++) send(1'b0, 32'(i), 0, 100);
    drain(2);
    n_checks++;
    if (obs_q.size() !== N) $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), N); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL stall_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random_gaps();
    do_reset();
    for (int i = 0; i < 2 * N; i++) send(1'(i % N == 0), 32'(i), 30, 70);
    drain(4);
    n_checks++;
    if (obs_q.size() !== 2 * N) $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), 2 * N); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_q.size() >= 2 * N) begin
      n_checks++; if (obs_q[256].sof !== 1'b1) $display("FAIL rand_sof_256: got %b expected 1", obs_q[256].sof); else n_pass++;
      n_checks++; if (obs_q[255].eof !== 1'b1) $display("FAIL rand_eof_255: got %b expected 1", obs_q[255].eof); else n_pass++;
      n_checks++; if (obs_q[511].eof !== 1'b1) $display("FAIL rand_eof_511: got %b expected 1", obs_q[511].eof); else n_pass++;
    end
    n_checks++; if (obs_err !== 0) $display("FAIL rand_ferr: got %0d pulses expected 0", obs_err); else n_pass++;
  endtask

  task automatic test_frame_err();
    do_reset();
    for (int i = 0; i < 57; i++) send(1'(i == 0), 32'(i), 0, 100);
    send(1'b1, 32'd57, 0, 100);
    for (int i = 58; i < 58 + 200; i++) send(1'b0, 32'(i), 0, 100);
    drain(3);
    n_checks++; if (obs_err !== 1) $display("FAIL ferr_pulses: got %0d expected 1", obs_err); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL ferr_model: got %0d expected %0d", obs_err, exp_err); else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL ferr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ferr_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    if (obs_q.size() >= 258) begin
      n_checks++; if (obs_q[57].sof !== 1'b1) $display("FAIL ferr_sof: got %b expected 1", obs_q[57].sof); else n_pass++;
      n_checks++; if (obs_q[57].angle !== 32'h0) $display("FAIL ferr_angle: got %h expected 0", obs_q[57].angle); else n_pass++;
      n_checks++; if (obs_q[57 + 128].angle !== 32'h0) $display("FAIL ferr_idx128: got %h expected 0", obs_q[57 + 128].angle); else n_pass++;
      n_checks++; if (obs_q[57 + 130].angle !== 32'hfffff36f) $display("FAIL ferr_idx130: got %h expected fffff36f", obs_q[57 + 130].angle); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    logic acc;
    int   nobs;
    do_reset();
    for (int i = 0; i <= 140; i++) send(1'(i == 0), 32'(i), 0, 100);
    repeat (2) step(1'b1, 1'b0, 32'd141, 32'h0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) $display("FAIL async_valid: got %b expected 0", bus.o_valid); else n_pass++;
    n_checks++; if (bus.o_ready !== 1'b1) $display("FAIL async_ready: got %b expected 1", bus.o_ready); else n_pass++;
    nobs = obs_q.size();
    n_checks++; if (nobs !== 140) $display("FAIL pre_rst_count: got %0d expected 140", nobs); else n_pass++;
    for (int i = 0; i < nobs && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL pre_rst_sample[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mpos = 0; exp_err = 0; obs_err = 0;
    exp_q.delete();
    obs_q.delete();
    send(1'b0, 32'hdead0001, 0, 100);
    drain(2);
    n_checks++; if (obs_q.size() !== 1) $display("FAIL post_rst_count: got %0d expected 1", obs_q.size()); else n_pass++;
    if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
      n_checks++; if (obs_q[0].sof !== 1'b1) $display("FAIL post_rst_sof: got %b expected 1", obs_q[0].sof); else n_pass++;
      n_checks++; if (obs_q[0].angle !== 32'h0) $display("FAIL post_rst_angle: got %h expected 0", obs_q[0].angle); else n_pass++;
      n_checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL post_rst_sample: got %h expected %h", obs_q[0], exp_q[0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_random_gaps();
    test_frame_err();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
